// File: rtl/cycle_sequencer_if.sv
// Request/strobe bundle between the cycle sequencer and the datapath it paces.
//   master modport : sequencer side (requests in, strobes/status out)
//   slave modport  : datapath side (requests out, strobes/status in)
// Signals: halt_req, wake, branch_req, skip_req (requests);
//          en_pc, en_imem, en_alu, en_regs, phase, nop_insert, sleeping (status);
//          retired (only when RETIRE_COUNT_EN is defined).
interface cycle_sequencer_if;
    logic        halt_req;
    logic        wake;
    logic        branch_req;
    logic        skip_req;
    logic        en_pc;
    logic        en_imem;
    logic        en_alu;
    logic        en_regs;
    logic [1:0]  phase;
    logic        nop_insert;
    logic        sleeping;
`ifdef RETIRE_COUNT_EN
    logic [15:0] retired;

    modport master (
        input  halt_req, wake, branch_req, skip_req,
        output en_pc, en_imem, en_alu, en_regs, phase, nop_insert, sleeping, retired
    );

    modport slave (
        output halt_req, wake, branch_req, skip_req,
        input  en_pc, en_imem, en_alu, en_regs, phase, nop_insert, sleeping, retired
    );
`else
    modport master (
        input  halt_req, wake, branch_req, skip_req,
        output en_pc, en_imem, en_alu, en_regs, phase, nop_insert, sleeping
    );

    modport slave (
        output halt_req, wake, branch_req, skip_req,
        input  en_pc, en_imem, en_alu, en_regs, phase, nop_insert, sleeping
    );
`endif
endinterface

// File: rtl/cycle_sequencer.sv
// Four-phase instruction cycle sequencer.
// Each instruction cycle is four master_clk phases; one strobe per phase
// (en_pc, en_imem, en_alu, en_regs). Branches and skips turn the following
// instruction into a NOP (FLUSH: fetch strobes only); halt_req enters SLEEP
// until wake.
// Ports:
//   master_clk : clock, all state changes on its rising edge
//   reset      : asynchronous active-high reset
//   bus        : cycle_sequencer_if.master (requests in, strobes/status out)
// Optional feature: define RETIRE_COUNT_EN to add the 16-bit retired counter.
module cycle_sequencer (
    input  logic              master_clk,
    input  logic              reset,
    cycle_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        StStartup,
        StRun,
        StFlush,
        StSleep
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       branch_pend_q, branch_pend_d;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StStartup;
            phase_q       <= 2'd0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q + 2'd1;
        branch_pend_d = branch_pend_q;

        // The pending branch only lives for the instruction that raised it.
        if (phase_q == 2'd3) begin
            branch_pend_d = 1'b0;
        end

        case (state_q)
            StStartup: begin
                if (phase_q == 2'd3) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (phase_q == 2'd2) begin
                    branch_pend_d = bus.branch_req;
                end
                if (phase_q == 2'd3) begin
                    if (bus.halt_req) begin
                        state_d = StSleep;
                    end else if (branch_pend_q || bus.skip_req) begin
                        state_d = StFlush;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StFlush: begin
                // branch_req/skip_req are deliberately not looked at here.
                if (phase_q == 2'd3) begin
                    state_d = bus.halt_req ? StSleep : StRun;
                end
            end
            StSleep: begin
                phase_d = 2'd0;
                if (bus.wake) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StStartup;
            end
        endcase
    end

    // Outputs come from registered state only, so no request input can glitch a strobe.
    always_comb begin
        bus.en_pc      = 1'b0;
        bus.en_imem    = 1'b0;
        bus.en_alu     = 1'b0;
        bus.en_regs    = 1'b0;
        bus.nop_insert = 1'b0;
        bus.sleeping   = 1'b0;
        bus.phase      = phase_q;

        case (state_q)
            StRun: begin
                bus.en_pc   = (phase_q == 2'd0);
                bus.en_imem = (phase_q == 2'd1);
                bus.en_alu  = (phase_q == 2'd2);
                bus.en_regs = (phase_q == 2'd3);
            end
            StFlush: begin
                bus.en_pc      = (phase_q == 2'd0);
                bus.en_imem    = (phase_q == 2'd1);
                bus.nop_insert = 1'b1;
            end
            StSleep: begin
                bus.sleeping = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef RETIRE_COUNT_EN
    logic [15:0] retired_q;

    // Counts instructions that actually executed; wraps naturally at 16 bits.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            retired_q <= 16'd0;
        end else if (state_q == StRun && phase_q == 2'd3) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.retired = retired_q;
`endif

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  master_clk  input  1  single clock; all state changes on its rising edge.
  reset  input  1  asynchronous, active-high reset.
  halt_req  input  1  SLEEP request from the executing instruction; sampled at phase 3.
  wake  input  1  level wake request; sampled only in SLEEP.
  branch_req  input  1  GOTO/CALL/RETURN in execution; sampled at phase 2.
  skip_req  input  1  DECFSZ/INCFSZ result zero; sampled at phase 3.
  en_pc  output  1  phase-0 strobe to the program counter.
  en_imem  output  1  phase-1 strobe to instruction memory and instruction register.
  en_alu  output  1  phase-2 strobe to the ALU.
  en_regs  output  1  phase-3 strobe to the W and file registers.
  phase  output  2  current phase count.
  nop_insert  output  1  current instruction cycle executes as NOP.
  sleeping  output  1  block is in SLEEP.
  retired  output  16  retired-instruction count (present only with RETIRE_COUNT_EN).
REQ-002 There SHALL be one clock (master_clk) and reset SHALL be asynchronous and active-high (reset); the polarity and synchronicity are fixed.

Function
REQ-003 The phase register SHALL be 2 bits, increment by one every master_clk, and wrap from 3 to 0, except in SLEEP.
REQ-004 Strobes SHALL be decoded from registered state and phase only, with no input-to-output combinational path.
REQ-005 At most one strobe SHALL be high in any cycle.
REQ-006 States SHALL be STARTUP, RUN, FLUSH and SLEEP.
REQ-007 STARTUP SHALL last exactly one phase sequence (phases 0-3) with all strobes low, then enter RUN at phase 0.
REQ-008 In RUN: en_pc=(phase==0), en_imem=(phase==1), en_alu=(phase==2), en_regs=(phase==3); nop_insert=0.
REQ-009 branch_req SHALL be captured into branch_pend on the phase-2 edge in RUN; branch_pend SHALL clear on every phase-3 edge.
REQ-010 On the phase-3 edge in RUN, the next state SHALL be decided with this priority: halt_req -> SLEEP; else branch_pend or skip_req -> FLUSH; else RUN.
REQ-011 FLUSH SHALL last one full phase sequence with nop_insert=1 and en_pc and en_imem active; en_alu and en_regs SHALL stay low.
REQ-012 branch_req and skip_req SHALL be ignored in FLUSH.
REQ-013 On the phase-3 edge in FLUSH, the next state SHALL be SLEEP if halt_req=1, else RUN.
REQ-014 In SLEEP: all strobes low, phase held at 0, sleeping=1.
REQ-015 In SLEEP, wake=1 SHALL move the state to RUN on the next edge, so en_pc is high in the following cycle.
REQ-016 halt_req and wake both high on a RUN phase-3 edge SHALL enter SLEEP; wake SHALL then be honoured one cycle later.
REQ-017 A flush request is lost when SLEEP is entered; after wake the block SHALL resume in RUN with nop_insert=0.

Reset
REQ-018 Asserting reset SHALL immediately force: state STARTUP, phase 0, branch_pend 0, all strobes 0, nop_insert 0, sleeping 0, retired 0.
REQ-019 Reset asserted mid-cycle in any state SHALL abort the current instruction cycle with no further strobe.
REQ-020 After reset deasserts, the first en_pc SHALL occur on the 5th rising edge (edge 4, counting from 0).

Configuration
REQ-021 With macro RETIRE_COUNT_EN defined, retired SHALL increment on every phase-3 edge in RUN (not in FLUSH, STARTUP or SLEEP) and wrap from 0xFFFF to 0x0000.
REQ-022 Without RETIRE_COUNT_EN, the retired port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  Reset release, all request inputs 0 -> four edges with no strobes, then strobe order en_pc, en_imem, en_alu, en_regs repeating; phase 0,1,2,3.
  branch_req=1 at phase 2 of instruction N -> instruction N+1 has nop_insert=1 with no en_alu/en_regs; instruction N+2 runs normally; with the macro, retired rises by 2 across N..N+2, not 3.
  skip_req=1 at phase 3 together with branch_req=1 at phase 2 -> exactly one FLUSH cycle.
  halt_req=1 at phase 3 -> sleeping=1 with strobes low for 20 cycles; wake=1 -> en_pc high in the second cycle after wake rises.
  reset pulsed during FLUSH phase 1 -> nop_insert=0 and strobes low immediately; restart per REQ-020.
  With RETIRE_COUNT_EN, 65536 RUN instructions -> retired wraps to 0x0000.
